// File: rtl/ntt_stride_permutation_if.sv
// Beat-stream interface for ntt_stride_permutation.
// Valid/ready contract: there is no ready and no valid; every clock cycle carries
// exactly one beat in each direction, and inStart marks beat 0 of a frame.
// outErr exists only when NTT_PERM_FRAME_CHECK_EN is defined.
interface ntt_stride_permutation_if #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32
);
  localparam int LOG_P = $clog2(INPUT_PER_CYCLE);
  localparam int MW    = $clog2(LOG_P + 1);
  localparam int DW    = INPUT_PER_CYCLE * DATA_WIDTH_PER_INPUT;

  logic          inStart;
  logic [MW-1:0] cfgSwapBit;
  logic [DW-1:0] inData;
  logic          outStart;
  logic [DW-1:0] outData;
`ifdef NTT_PERM_FRAME_CHECK_EN
  logic          outErr;

  modport master (output inStart, cfgSwapBit, inData, input outStart, outData, outErr);
  modport slave  (input inStart, cfgSwapBit, inData, output outStart, outData, outErr);
`else
  modport master (output inStart, cfgSwapBit, inData, input outStart, outData);
  modport slave  (input inStart, cfgSwapBit, inData, output outStart, outData);
`endif
endinterface

// File: rtl/ntt_stride_permutation.sv
// Runtime-configurable lane permutation between NTT butterfly stages.
// Modes: 0 bypass, 1..LOG_P-1 swap lane bits 0 and k, LOG_P swap lane bit 0 with
// beat bit 0 across a beat pair. Fixed 2-cycle latency in all modes.
// Optional frame checking (sticky outErr) is enabled by NTT_PERM_FRAME_CHECK_EN.
module ntt_stride_permutation #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32,
  parameter int N                    = 1024
) (
  input logic                     clk,
  input logic                     rst,
  ntt_stride_permutation_if.slave bus
);
  localparam int W     = DATA_WIDTH_PER_INPUT;
  localparam int P     = INPUT_PER_CYCLE;
  localparam int LOG_P = $clog2(P);
  localparam int MW    = $clog2(LOG_P + 1);
  localparam int DW    = P * W;
  localparam int BEATS = N / P;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BEATS - 1);
  localparam logic [MW-1:0] CROSS_MODE = MW'(LOG_P);

  // Out lane i takes in lane i with bits 0 and k exchanged; k=0 is identity.
  function automatic logic [DW-1:0] swap_in_beat(input logic [DW-1:0] d, input int k);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < P; i++) begin
      int src;
      src = i;
      if (((i >> k) & 1) != (i & 1)) src = i ^ ((1 << k) | 1);
      r[i*W +: W] = d[src*W +: W];
    end
    return r;
  endfunction

  // Even beat of a pair: even lanes from itself, odd lanes from the partner's even lanes.
  function automatic logic [DW-1:0] cross_even(input logic [DW-1:0] own, input logic [DW-1:0] mate);
    logic [DW-1:0] r;
    r = '0;
    for (int m = 0; m < P / 2; m++) begin
      r[(2*m)*W +: W]   = own[(2*m)*W +: W];
      r[(2*m+1)*W +: W] = mate[(2*m)*W +: W];
    end
    return r;
  endfunction

  // Odd beat of a pair: even lanes from the held even beat's odd lanes, odd lanes from itself.
  function automatic logic [DW-1:0] cross_odd(input logic [DW-1:0] held, input logic [DW-1:0] own);
    logic [DW-1:0] r;
    r = '0;
    for (int m = 0; m < P / 2; m++) begin
      r[(2*m)*W +: W]   = held[(2*m+1)*W +: W];
      r[(2*m+1)*W +: W] = own[(2*m+1)*W +: W];
    end
    return r;
  endfunction

  logic [CW-1:0] beat_cnt;
  logic [MW-1:0] active_mode;
  logic [DW-1:0] s1_data;
  logic          s1_start;
  logic [MW-1:0] s1_mode;
  logic          s1_odd;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] out_data;
  logic          out_start;

  logic [CW-1:0] in_beat;
  logic [MW-1:0] cfg_mode;
  logic [MW-1:0] in_mode;
  logic [DW-1:0] partner;
  logic [DW-1:0] next_out;

  // Beat index and mode for the live beat; out-of-range modes fall back to bypass.
  always_comb begin
    cfg_mode = (int'(bus.cfgSwapBit) > LOG_P) ? '0 : bus.cfgSwapBit;
    in_beat  = bus.inStart ? '0 : beat_cnt;
    in_mode  = bus.inStart ? cfg_mode : active_mode;
  end

  // Stage 1: count beats, latch the frame mode and capture the beat with its own mode and parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt    <= '0;
      active_mode <= '0;
      s1_data     <= '0;
      s1_start    <= 1'b0;
      s1_mode     <= '0;
      s1_odd      <= 1'b0;
    end else begin
      beat_cnt    <= (in_beat == LAST_BEAT) ? '0 : in_beat + CW'(1);
      active_mode <= in_mode;
      s1_data     <= bus.inData;
      s1_start    <= bus.inStart;
      s1_mode     <= in_mode;
      s1_odd      <= in_beat[0];
    end
  end

  // Build the permuted beat; a new frame never lends partner data to an aborted pair.
  always_comb begin
    partner = bus.inStart ? '0 : bus.inData;
    if (s1_mode == CROSS_MODE) begin
      next_out = s1_odd ? cross_odd(hold_data, s1_data) : cross_even(s1_data, partner);
    end else begin
      next_out = swap_in_beat(s1_data, int'(s1_mode));
    end
  end

  // Stage 2: register the output beat and keep the previous stage-1 beat as the odd beat's partner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_start <= 1'b0;
      hold_data <= '0;
    end else begin
      out_data  <= next_out;
      out_start <= s1_start;
      hold_data <= s1_data;
    end
  end

  assign bus.outData  = out_data;
  assign bus.outStart = out_start;

`ifdef NTT_PERM_FRAME_CHECK_EN
  logic err;

  // Sticky flag for a restart mid-frame or an out-of-range mode at frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (bus.inStart && (beat_cnt != '0 || int'(bus.cfgSwapBit) > LOG_P)) begin
      err <= 1'b1;
    end
  end

  assign bus.outErr = err;
`endif
endmodule

// File: tb/tb_ntt_stride_permutation.sv
// Bench for ntt_stride_permutation: directed frames with hand-computed lanes plus a
// frame-level reference model scored through an expected queue.
`timescale 1ns/1ps
module tb_ntt_stride_permutation;
  localparam int W     = 32;
  localparam int P     = 32;
  localparam int N     = 1024;
  localparam int LOG_P = 5;
  localparam int MW    = 3;
  localparam int BEATS = N / P;
  localparam int DW    = P * W;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ntt_stride_permutation_if #(.DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(P)) bus ();

  ntt_stride_permutation #(
    .DATA_WIDTH_PER_INPUT(W),
    .INPUT_PER_CYCLE(P),
    .N(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock
  always #5 clk = ~clk;

  logic [DW-1:0] in_q[$];
  logic          st_q[$];
  int            cfg_q[$];
  logic [DW-1:0] obs_q[$];
  logic          obs_st_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_st_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input logic [DW-1:0] d, input int i);
    return d[i*W +: W];
  endfunction

  function automatic logic [DW-1:0] ramp(input int base, input int mult, input int b);
    logic [DW-1:0] d;
    for (int i = 0; i < P; i++) d[i*W +: W] = W'(base + mult * b + i);
    return d;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int i = 0; i < P; i++) d[i*W +: W] = $urandom;
    return d;
  endfunction

  // Driver: one beat per cycle; output sampled 1ns after the edge.
  // obs_q[k] holds the output for input k-1 (two-cycle latency).
  task automatic step(input logic start, input int cfg, input logic [DW-1:0] data);
    bus.inStart    = start;
    bus.cfgSwapBit = MW'(cfg);
    bus.inData     = data;
    in_q.push_back(data);
    st_q.push_back(start);
    cfg_q.push_back(cfg);
    @(posedge clk);
    #1;
    obs_q.push_back(bus.outData);
    obs_st_q.push_back(bus.outStart);
  endtask

  // Reference: out beat with parity bo, lane 2m+c = in beat (pair base + c), lane 2m+bo.
  function automatic logic [DW-1:0] model_beat(input int t, input int b, input int m);
    logic [DW-1:0] r;
    int src_t, src_l, bo, c, b0, bk;
    r = '0;
    for (int l = 0; l < P; l++) begin
      if (m == LOG_P) begin
        bo = b & 1;
        c  = l & 1;
        src_t = (c == bo) ? t : ((bo == 0) ? t + 1 : t - 1);
        src_l = (l & ~1) | bo;
        if (src_t == t || (src_t == t + 1 && !st_q[t+1]) || (src_t == t - 1 && t >= 1))
          r[l*W +: W] = lane(in_q[src_t], src_l);
      end else begin
        b0 = l & 1;
        bk = (l >> m) & 1;
        src_l = (l & ~((1 << m) | 1)) | bk | (b0 << m);
        r[l*W +: W] = lane(in_q[t], src_l);
      end
    end
    return r;
  endfunction

  // Scoreboard: derive beat index/mode per input, fill exp_q, compare every lane, clear.
  task automatic score_segment(input string tag);
    int n, b, m;
    int beat_a[$];
    int mode_a[$];
    logic [DW-1:0] e;
    logic es;
    n = in_q.size();
    b = -1;
    m = 0;
    for (int t = 0; t < n; t++) begin
      if (st_q[t]) begin
        b = 0;
        m = (cfg_q[t] > LOG_P) ? 0 : cfg_q[t];
      end else begin
        b = (b + 1) % BEATS;
      end
      beat_a.push_back(b);
      mode_a.push_back(m);
    end
    exp_q.push_back('0);
    exp_st_q.push_back(1'b0);
    for (int t = 0; t < n - 1; t++) begin
      exp_q.push_back(model_beat(t, beat_a[t], mode_a[t]));
      exp_st_q.push_back(st_q[t]);
    end
    for (int s = 0; s < n; s++) begin
      e  = exp_q.pop_front();
      es = exp_st_q.pop_front();
      check_val($sformatf("%s start c%0d", tag, s), 32'(obs_st_q[s]), 32'(es));
      for (int i = 0; i < P; i++)
        check_val($sformatf("%s c%0d lane%0d", tag, s, i), lane(obs_q[s], i), lane(e, i));
    end
    in_q.delete(); st_q.delete(); cfg_q.delete(); obs_q.delete(); obs_st_q.delete();
  endtask

  initial begin
    int a2, a3, a4, a5, a6, a7, mode, len;
    bus.inStart    = 1'b0;
    bus.cfgSwapBit = '0;
    bus.inData     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("reset outStart", 32'(bus.outStart), 32'd0);
    check_val("reset lane0", lane(bus.outData, 0), 32'd0);
    check_val("reset lane31", lane(bus.outData, 31), 32'd0);
`ifdef NTT_PERM_FRAME_CHECK_EN
    check_val("reset outErr", 32'(bus.outErr), 32'd0);
`endif
    @(negedge clk) rst = 1'b1;

    // Idle beats: cfg is ignored without inStart, so bypass; counter wraps back to 0
    for (int k = 0; k < BEATS; k++) step(1'b0, 4, rand_beat());
`ifdef NTT_PERM_FRAME_CHECK_EN
    check_val("err before frames", 32'(bus.outErr), 32'd0);
`endif

    // T2: mode 4, lane i = i + 100
    a2 = in_q.size();
    for (int k = 0; k < BEATS; k++) step(k == 0, 4, ramp(100, 0, k));
    // T3: cross mode, beat b lane i = 1000*b + i
    a3 = in_q.size();
    for (int k = 0; k < BEATS; k++) step(k == 0, 5, ramp(0, 1000, k));
    // T4: mode 1 then mode 5 back to back
    a4 = in_q.size();
    for (int k = 0; k < BEATS; k++) step(k == 0, 1, ramp(5000, 100, k));
    a5 = in_q.size();
    for (int k = 0; k < BEATS; k++) step(k == 0, 5, ramp(9000, 100, k));
`ifdef NTT_PERM_FRAME_CHECK_EN
    check_val("err clean frames", 32'(bus.outErr), 32'd0);
`endif
    // T5: cross frame cut after beat 6, then a fresh cross frame
    a6 = in_q.size();
    for (int k = 0; k < 7; k++) step(k == 0, 5, ramp(20000, 100, k));
    a7 = in_q.size();
    for (int k = 0; k < BEATS; k++) step(k == 0, 5, ramp(30000, 100, k));
    step(1'b0, 0, rand_beat());
    step(1'b0, 0, rand_beat());
`ifdef NTT_PERM_FRAME_CHECK_EN
    check_val("err after abort", 32'(bus.outErr), 32'd1);
`endif

    check_val("idle bypass lane3", lane(obs_q[1], 3), lane(in_q[0], 3));
    check_val("t2 start early", 32'(obs_st_q[a2]), 32'd0);
    check_val("t2 start", 32'(obs_st_q[a2+1]), 32'd1);
    check_val("t2 start once", 32'(obs_st_q[a2+2]), 32'd0);
    check_val("t2 out0", lane(obs_q[a2+1], 0), 32'd100);
    check_val("t2 out1", lane(obs_q[a2+1], 1), 32'd116);
    check_val("t2 out16", lane(obs_q[a2+1], 16), 32'd101);
    check_val("t2 out17", lane(obs_q[a2+1], 17), 32'd117);
    check_val("t3 b0 l0", lane(obs_q[a3+1], 0), 32'd0);
    check_val("t3 b0 l1", lane(obs_q[a3+1], 1), 32'd1000);
    check_val("t3 b1 l0", lane(obs_q[a3+2], 0), 32'd1);
    check_val("t3 b1 l1", lane(obs_q[a3+2], 1), 32'd1001);
    check_val("t3 b2 l2", lane(obs_q[a3+3], 2), 32'd2002);
    check_val("t3 b2 l1", lane(obs_q[a3+3], 1), 32'd3000);
    check_val("t3 b3 l0", lane(obs_q[a3+4], 0), 32'd2001);
    check_val("t4 last l0", lane(obs_q[a5], 0), 32'd8100);
    check_val("t4 last l1", lane(obs_q[a5], 1), 32'd8102);
    check_val("t4 last l2", lane(obs_q[a5], 2), 32'd8101);
    check_val("t4 last start", 32'(obs_st_q[a5]), 32'd0);
    check_val("t4 next start", 32'(obs_st_q[a5+1]), 32'd1);
    check_val("t4 next l0", lane(obs_q[a5+1], 0), 32'd9000);
    check_val("t4 next l1", lane(obs_q[a5+1], 1), 32'd9100);
    check_val("t4 next l3", lane(obs_q[a5+1], 3), 32'd9102);
    check_val("t5 b5 l0", lane(obs_q[a6+6], 0), 32'd20401);
    check_val("t5 b5 l1", lane(obs_q[a6+6], 1), 32'd20501);
    check_val("t5 b6 l0", lane(obs_q[a7], 0), 32'd20600);
    check_val("t5 b6 l1", lane(obs_q[a7], 1), 32'd0);
    check_val("t5 b6 l2", lane(obs_q[a7], 2), 32'd20602);
    check_val("t5 b6 l31", lane(obs_q[a7], 31), 32'd0);
    check_val("t5 new start", 32'(obs_st_q[a7+1]), 32'd1);
    check_val("t5 new l0", lane(obs_q[a7+1], 0), 32'd30000);
    check_val("t5 new l1", lane(obs_q[a7+1], 1), 32'd30100);
    score_segment("seg_a");

    // T1: reset mid-stream clears outputs without waiting for a clock edge
    step(1'b1, 0, ramp(40000, 100, 0));
    step(1'b0, 0, ramp(40000, 100, 1));
    check_val("pre reset lane0", lane(bus.outData, 0), 32'd40000);
    #3;
    rst = 1'b0;
    #1;
    check_val("async reset start", 32'(bus.outStart), 32'd0);
    check_val("async reset lane0", lane(bus.outData, 0), 32'd0);
    check_val("async reset lane1", lane(bus.outData, 1), 32'd0);
    in_q.delete(); st_q.delete(); cfg_q.delete(); obs_q.delete(); obs_st_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
`ifdef NTT_PERM_FRAME_CHECK_EN
    check_val("err cleared", 32'(bus.outErr), 32'd0);
`endif

    // After reset: bypass until a fresh inStart, even with cfg set to cross
    for (int k = 0; k < 3; k++) step(1'b0, 5, rand_beat());
    check_val("post reset bypass l1", lane(obs_q[2], 1), lane(in_q[1], 1));

    // T6: random frames over all modes, including out-of-range and cut frames
    for (int f = 0; f < 200; f++) begin
      mode = (f < 16) ? (f % 8) : $urandom_range(0, 7);
      len  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, BEATS - 1) : BEATS;
      for (int k = 0; k < len; k++)
        step(k == 0, (k == 0) ? mode : $urandom_range(0, 7), rand_beat());
    end
    step(1'b0, 0, rand_beat());
    step(1'b0, 0, rand_beat());
`ifdef NTT_PERM_FRAME_CHECK_EN
    check_val("err after random", 32'(bus.outErr), 32'd1);
`endif
    score_segment("seg_b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
